handshake_sender: RTL and testbench

- Initiator side of the 4-phase send/ack word handshake used by the peripheral receiver FSM.
- Buffers words written by the local processor logic in a small FIFO.
- Drives `send`/`data` to the peripheral, one word at a time, following full 4-phase handshaking.
- Sits between the processor-side write port and the peripheral's `send`/`data`/`outack` inputs.

---
 rtl/handshake_sender.sv | 133 +++++++++++++
 tb/tb_handshake_sender.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_sender.sv
// Initiator side of the 4-phase send/ack word handshake: a small FIFO feeds an IDLE/REQ/RELEASE FSM.
// send/data are registered. Pushes while full are dropped and flagged; REQ aborts after TIMEOUT cycles without ack.
module handshake_sender #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic              send,
  output logic [DATA_W-1:0] data,
  input  logic              ack,
  output logic              busy,
  output logic [CNT_W-1:0]  sent_count,
  output logic              overflow,
  output logic              timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [AW:0]       cnt;
  logic              push, pop;
  logic [TW-1:0]     tcnt, tcnt_nxt;
  logic              aborted, aborted_nxt;
  logic              send_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              inc_sent, set_tout;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  // Full is judged before this cycle's pop, so a push into a full FIFO is lost even if a pop frees a slot.
  assign push  = wr_en && !full;
  assign busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    send_nxt    = send;
    data_nxt    = data;
    tcnt_nxt    = tcnt;
    aborted_nxt = aborted;
    pop         = 1'b0;
    inc_sent    = 1'b0;
    set_tout    = 1'b0;
    case (state)
      IDLE: begin
        send_nxt = 1'b0;
        if (!empty) begin
          data_nxt    = mem[rptr];
          send_nxt    = 1'b1;
          tcnt_nxt    = '0;
          aborted_nxt = 1'b0;
          state_nxt   = REQ;
        end
      end
      REQ: begin
        if (ack) begin
          send_nxt  = 1'b0;
          state_nxt = RELEASE;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          // This wait-cycle brings the count to TIMEOUT: give up on the word.
          send_nxt    = 1'b0;
          set_tout    = 1'b1;
          aborted_nxt = 1'b1;
          state_nxt   = RELEASE;
        end else begin
          tcnt_nxt = tcnt + TW'(1);
        end
      end
      RELEASE: begin
        if (!ack) begin
          pop       = !empty;
          inc_sent  = !aborted;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      send        <= 1'b0;
      data        <= '0;
      tcnt        <= '0;
      aborted     <= 1'b0;
      sent_count  <= '0;
      timeout_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      send    <= send_nxt;
      data    <= data_nxt;
      tcnt    <= tcnt_nxt;
      aborted <= aborted_nxt;
      if (inc_sent) sent_count <= sent_count + CNT_W'(1);
      if (set_tout) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_handshake_sender.sv
// Directed bench for handshake_sender: a scripted peripheral drives ack, a monitor logs delivered words.
module tb_handshake_sender;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic        full, empty, send, busy, overflow, timeout_err;
  logic [15:0] data;
  logic        ack = 1'b0;
  logic [7:0]  sent_count;

  int total = 0;
  int bad = 0;

  // Peripheral: in auto mode ack mirrors send one cycle late, otherwise ack_force is driven.
  bit ack_auto = 1'b0;
  bit ack_force = 1'b0;

  logic [15:0] dq[$];
  logic [15:0] held;
  bit          prev_send = 1'b0;
  bit          have_fall = 1'b0;
  int          cyc_n = 0;
  int          fall_n = 0;
  int          min_gap = 99;

  handshake_sender #(.DATA_W(16), .DEPTH(4), .TIMEOUT(15), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full), .empty(empty),
    .send(send), .data(data), .ack(ack), .busy(busy), .sent_count(sent_count),
    .overflow(overflow), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      ack = ack_auto ? send : ack_force;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (send && !prev_send) begin
        dq.push_back(data);
        if (have_fall && (cyc_n - fall_n) < min_gap) min_gap = cyc_n - fall_n;
        held = data;
      end else if (send && prev_send) begin
        chk("data_hold", data, held);
      end
      if (!send && prev_send) begin
        fall_n = cyc_n;
        have_fall = 1'b1;
      end
      prev_send = send;
      cyc_n++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    wr_en = 1'b0;
    ack_auto = 1'b0;
    ack_force = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    dq.delete();
    have_fall = 1'b0;
    min_gap = 99;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(!busy && empty) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", (!busy && empty), 1);
  endtask

  task automatic wait_send(input logic v, input int budget);
    int n = 0;
    while (send !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("send_reached", send, v);
  endtask

  task automatic check_words(input string tag, input logic [15:0] base, input int n);
    chk({tag, "_count"}, dq.size(), n);
    for (int i = 0; i < n; i++)
      chk({tag, "_word"}, (i < dq.size()) ? {16'h0, dq[i]} : 32'hDEAD_BEEF, base + 16'(i));
  endtask

  initial begin
    int hi;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_send", send, 0);
    chk("rst_data", data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", sent_count, 0);
    chk("rst_flags", {overflow, timeout_err}, 0);

    // Ack seen in IDLE is ignored
    ack_force = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ack_busy", busy, 0);
    chk("idle_ack_count", sent_count, 0);

    // Single word
    do_reset();
    ack_auto = 1'b1;
    wr_en = 1'b1;
    wr_data = 16'h00A5;
    @(negedge clk);
    wr_en = 1'b0;
    chk("single_empty_fell", empty, 0);
    chk("single_send_not_yet", send, 0);
    @(negedge clk);
    chk("single_send_rose", send, 1);
    chk("single_data", data, 16'h00A5);
    wait_idle(20);
    chk("single_count", sent_count, 1);
    chk("single_busy", busy, 0);
    check_words("single", 16'h00A5, 1);

    // Burst of four, ack held low until the FIFO has filled
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      wr_en = 1'b1;
      wr_data = 16'(i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    chk("burst_full", full, 1);
    ack_auto = 1'b1;
    wait_idle(100);
    check_words("burst", 16'h0001, 4);
    chk("burst_count", sent_count, 4);
    chk("burst_gap_ge2", (min_gap >= 2), 1);

    // Overflow: fifth push into a full FIFO is lost
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        chk("ovf_full_before", full, 1);
        chk("ovf_clear_before", overflow, 0);
      end
      wr_en = 1'b1;
      wr_data = 16'h0010 + 16'(i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("ovf_still_full", full, 1);
    ack_auto = 1'b1;
    wait_idle(100);
    check_words("ovf", 16'h0010, 4);
    chk("ovf_count", sent_count, 4);
    chk("ovf_sticky", overflow, 1);

    // Timeout with ack stuck low
    do_reset();
    wr_en = 1'b1;
    wr_data = 16'h0BEE;
    @(negedge clk);
    wr_en = 1'b0;
    wait_send(1'b1, 10);
    hi = 0;
    while (send && hi < 40) begin
      hi++;
      @(negedge clk);
    end
    chk("tout_send_cycles", hi, 15);
    chk("tout_err", timeout_err, 1);
    wait_idle(10);
    chk("tout_count", sent_count, 0);
    chk("tout_popped", empty, 1);
    chk("tout_sticky", timeout_err, 1);

    // Slow release: ack held high six cycles after send falls
    do_reset();
    for (int i = 0; i < 2; i++) begin
      wr_en = 1'b1;
      wr_data = 16'h0C01 + 16'(i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    wait_send(1'b1, 10);
    ack_force = 1'b1;
    wait_send(1'b0, 10);
    for (int i = 0; i < 6; i++) begin
      chk("slow_send_low", send, 0);
      chk("slow_in_release", busy, 1);
      @(negedge clk);
    end
    chk("slow_word_kept", empty, 0);
    chk("slow_count_held", sent_count, 0);
    ack_force = 1'b0;
    wait_send(1'b1, 10);
    chk("slow_next_data", data, 16'h0C02);
    ack_auto = 1'b1;
    wait_idle(30);
    chk("slow_count", sent_count, 2);
    check_words("slow", 16'h0C01, 2);

    // Reset in the middle of REQ with words queued and overflow set
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1;
      wr_data = 16'h0D01 + 16'(i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    chk("mid_send_high", send, 1);
    chk("mid_ovf_before", overflow, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_send", send, 0);
    chk("mid_empty", empty, 1);
    chk("mid_count", sent_count, 0);
    chk("mid_flags", {overflow, timeout_err}, 0);
    chk("mid_data", data, 0);
    repeat (3) @(negedge clk);
    chk("mid_stays_idle", {busy, send}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
